// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm scheduler
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEEP   = 2'd1,
    GAP    = 2'd2,
    SNOOZE = 2'd3
  } alarm_state_t;

  localparam int SRC_CLOCK = 0;
  localparam int SRC_TIMER = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - up-counter with synchronous clear and a done flag at len_i-1
module cycle_timer #(
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic [CW:0] len_i,
  output logic        done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at the last count instead of wrapping if the owner does not clear it.
  always_comb begin
    done_o = ({1'b0, cnt_q} == (len_i - (CW+1)'(1)));
    if (clear_i)     cnt_d = '0;
    else if (done_o) cnt_d = cnt_q;
    else             cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - two-source alarm arbiter with beep/gap cadence, snooze and auto-timeout
// alarm_trigger feeds the enable of the external tone generator.
module alarm_scheduler #(
  parameter int BEEP_CYCLES   = 25_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int MAX_BEEPS     = 60,
  parameter int SNOOZE_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       alarm_trigger,
  output logic [1:0] active_src,
  output logic       timeout
);
  import alarm_pkg::*;

  localparam int MAX_LEN = max3(BEEP_CYCLES, GAP_CYCLES, SNOOZE_CYCLES);
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BW      = $clog2(MAX_BEEPS + 1);

  localparam logic [CW:0]   BEEP_LEN   = (CW+1)'(BEEP_CYCLES);
  localparam logic [CW:0]   GAP_LEN    = (CW+1)'(GAP_CYCLES);
  localparam logic [CW:0]   SNOOZE_LEN = (CW+1)'(SNOOZE_CYCLES);
  localparam logic [BW-1:0] LAST_BEEP  = BW'(MAX_BEEPS - 1);

  alarm_state_t  state_q, state_d;
  logic [1:0]    armed_q, armed_d;
  logic [1:0]    owner_q, owner_d;
  logic [BW-1:0] beeps_q, beeps_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    grantable, disarm;
  logic          owner_req;
  logic          tmr_clear, tmr_done;
  logic [CW:0]   tmr_len;

  cycle_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (tmr_clear),
    .len_i   (tmr_len),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 2'b00;
      owner_q   <= 2'b00;
      beeps_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      owner_q   <= owner_d;
      beeps_q   <= beeps_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority while active: dismiss, owner drop, snooze, then the cadence timer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    beeps_d   = beeps_q;
    timeout_d = 1'b0;
    disarm    = 2'b00;
    grantable = req & armed_q;
    owner_req = |(req & owner_q);

    case (state_q)
      IDLE: begin
        if (|grantable) begin
          state_d = BEEP;
          owner_d = grantable[SRC_CLOCK] ? 2'(1 << SRC_CLOCK) : 2'(1 << SRC_TIMER);
          beeps_d = '0;
        end
      end
      default: begin
        if (dismiss) begin
          state_d = IDLE;
          disarm  = owner_q;
        end else if (!owner_req) begin
          state_d = IDLE;
        end else if (snooze && (state_q != SNOOZE)) begin
          state_d = SNOOZE;
        end else if (tmr_done) begin
          if (state_q == BEEP) begin
            beeps_d = beeps_q + BW'(1);
            if (beeps_q == LAST_BEEP) begin
              state_d   = IDLE;
              timeout_d = 1'b1;
              disarm    = owner_q;
            end else begin
              state_d = GAP;
            end
          end else begin
            state_d = BEEP;
          end
        end
      end
    endcase

    if (state_d == IDLE) owner_d = 2'b00;

    // A low request re-arms its source even in the cycle it is disarmed.
    armed_d   = (armed_q & ~disarm) | ~req;
    tmr_clear = (state_q == IDLE) || (state_d != state_q);

    case (state_q)
      GAP:     tmr_len = GAP_LEN;
      SNOOZE:  tmr_len = SNOOZE_LEN;
      default: tmr_len = BEEP_LEN;
    endcase
  end

  always_comb begin
    alarm_trigger = (state_q == BEEP);
    active_src    = owner_q;
    timeout       = timeout_q;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 The module SHALL have parameter BEEP_CYCLES, default 25_000_000, giving tone-on length in clk cycles.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 25_000_000, giving silence length between beeps in clk cycles.
REQ-003 The module SHALL have parameter MAX_BEEPS, default 60, giving the beep count before auto-timeout.
REQ-004 The module SHALL have parameter SNOOZE_CYCLES, default 500_000_000, giving the snooze silence length in clk cycles.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port req, input, 2 bits: level alarm requests; req[0] is the clock alarm, req[1] is the countdown timer.
REQ-008 The module SHALL have port snooze, input, 1 bit: single-cycle synchronous pulse.
REQ-009 The module SHALL have port dismiss, input, 1 bit: single-cycle synchronous pulse.
REQ-010 The module SHALL have port alarm_trigger, output, 1 bit: drives the tone generator enable.
REQ-011 The module SHALL have port active_src, output, 2 bits: one-hot owner of the alarm, 0 when IDLE.
REQ-012 The module SHALL have port timeout, output, 1 bit: one-cycle pulse on auto-stop.

Function
REQ-013 The FSM SHALL have states IDLE, BEEP, GAP, SNOOZE, encoded per the package enum.
REQ-014 Each source SHALL have an armed flag, set while req[i]=0, and a source SHALL be grantable only while req[i]=1 and armed[i]=1.
REQ-015 In IDLE with any grantable source, the FSM SHALL grant the lowest index (req[0] has priority), load active_src, clear the cycle counter and beep count, and enter BEEP on the next edge.
REQ-016 alarm_trigger SHALL be 1 exactly when state==BEEP (registered, no combinational path from inputs).
REQ-017 BEEP SHALL last exactly BEEP_CYCLES cycles; on exit the beep count SHALL increment.
REQ-018 BEEP SHALL go to GAP, or to IDLE with timeout=1 for one cycle when the beep count reaches MAX_BEEPS.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles and then return to BEEP.
REQ-020 snooze in BEEP or GAP SHALL enter SNOOZE and clear the cycle counter, but SHALL NOT change the beep count.
REQ-021 SNOOZE SHALL last SNOOZE_CYCLES cycles and then return to BEEP with the cycle counter cleared.
REQ-022 snooze in IDLE or SNOOZE SHALL be ignored.
REQ-023 dismiss in BEEP, GAP or SNOOZE SHALL go to IDLE next cycle and clear armed[owner].
REQ-024 dismiss in IDLE SHALL be ignored.
REQ-025 If dismiss and snooze arrive in the same cycle, dismiss SHALL win.
REQ-026 Timeout SHALL clear armed[owner].
REQ-027 If the owner's req drops while the FSM is active, the FSM SHALL return to IDLE next cycle with no timeout pulse, and armed SHALL remain set.
REQ-028 A request from the non-owner while active SHALL be held pending, with no preemption; it SHALL be granted on return to IDLE if still grantable.
REQ-029 The cycle counter width SHALL be $clog2 of the largest of BEEP_CYCLES, GAP_CYCLES and SNOOZE_CYCLES, and the counter SHALL never wrap.
REQ-030 The beep count width SHALL be $clog2(MAX_BEEPS+1).
REQ-031 Transitions SHALL occur when counter==LEN-1, giving exact lengths.

Reset
REQ-032 On reset_n=0 (async assert), the FSM SHALL go to IDLE with alarm_trigger=0, active_src=0, timeout=0, counters=0 and armed=2'b00.
REQ-033 armed SHALL remain 0 after reset until req[i] is seen low, so no alarm fires from a request already high at reset.
REQ-034 Reset asserted mid-BEEP SHALL drop alarm_trigger immediately, without waiting for a clk edge.
REQ-035 Deassertion SHALL be synchronised externally, and the block SHALL assume a synchronous release.

Structure
REQ-036 Package alarm_pkg SHALL hold the state enum alarm_state_t and the source-index constants SRC_CLOCK=0 and SRC_TIMER=1.
REQ-037 The block SHALL use one sub-module, cycle_timer (load/clear, LEN input, done pulse), shared by all timed states.
REQ-038 alarm_scheduler SHALL instantiate the existing tone generator externally, connecting alarm_trigger to it.

Verification (bench params BEEP_CYCLES=4, GAP_CYCLES=3, MAX_BEEPS=3, SNOOZE_CYCLES=10)
REQ-039 Release reset with req=00, then raise req=01 -> BEEP starts next cycle, alarm_trigger pattern 4 on/3 off/4 on/3 off/4 on, then timeout pulses once, IDLE, active_src=00; holding req=01 SHALL NOT retrigger.
REQ-040 Raise req=11 together -> active_src=01; dismiss -> IDLE, then active_src=10 one cycle later and beeping resumes.
REQ-041 Pulse snooze in the 2nd BEEP cycle -> alarm_trigger=0 for exactly 10 cycles, then a full 4-cycle BEEP; total beeps before timeout still 3.
REQ-042 Assert snooze and dismiss in the same cycle -> IDLE, no SNOOZE entry, armed[owner]=0.
REQ-043 Hold req=01 through reset release -> no alarm; drop req then raise it -> alarm starts.
REQ-044 Assert reset_n=0 mid-BEEP between clk edges -> alarm_trigger falls immediately and all outputs are 0.
